// File: rtl/foo_sched.sv
// Round-robin scheduler sharing one foo datapath among NUM_REQ requesters, with an in-order response FIFO.
// Define FOO_SCHED_STATS_EN to add saturating issue/stall counters.
module foo_sched #(
  parameter int NUM_REQ    = 2,
  parameter int ID_W       = 1,
  parameter int DP_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*64-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  dp_valid,
  output logic [63:0]           dp_a,
  output logic [128:0]          dp_long_in,
  input  logic [63:0]           dp_x,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [63:0]           rsp_data
`ifdef FOO_SCHED_STATS_EN
  ,
  output logic [31:0]           stat_issue_cnt,
  output logic [31:0]           stat_stall_cnt
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [63:0]                       ops [NUM_REQ];
  logic [ID_W-1:0]                   ptr, gnt_id, dp_id;
  logic [NUM_REQ-1:0]                grant;
  logic [63:0]                       sel_data;
  logic                              credit, accept, push, pop;
  logic [CW-1:0]                     outstanding, count;
  logic [AW-1:0]                     wr_ptr, rd_ptr;
  logic [FIFO_DEPTH-1:0][ID_W+63:0]  mem;
  logic [DP_LATENCY-1:0]             tag_v;
  logic [DP_LATENCY-1:0][ID_W-1:0]   tag_id;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ops
    assign ops[g] = req_data[64*g+63:64*g];
  end

  assign credit = outstanding < CW'(FIFO_DEPTH);

  always_comb begin
    logic            found;
    logic [ID_W-1:0] idx;
    grant    = '0;
    gnt_id   = '0;
    sel_data = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((32'(ptr) + i) % NUM_REQ);
      if (credit && !found && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        gnt_id      = idx;
        sel_data    = ops[idx];
      end
    end
  end

  // Gated by rst_n so the grant reads zero during reset even with requests held.
  assign req_ready  = grant & {NUM_REQ{rst_n}};
  assign accept     = |(req_valid & req_ready);
  assign dp_long_in = {1'b0, dp_a, dp_a};

  assign rsp_valid          = count != '0;
  assign pop                = rsp_valid & rsp_ready;
  assign push               = tag_v[DP_LATENCY-1];
  assign {rsp_id, rsp_data} = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      outstanding <= '0;
      dp_valid    <= 1'b0;
      dp_a        <= '0;
      dp_id       <= '0;
    end else begin
      dp_valid <= accept;
      if (accept) begin
        dp_a  <= sel_data;
        dp_id <= gnt_id;
        ptr   <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
      end
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Tag shift register keeps the requester ID aligned with dp_x.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v  <= DP_LATENCY'({tag_v, dp_valid});
      tag_id <= (DP_LATENCY*ID_W)'({tag_id, dp_id});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {tag_id[DP_LATENCY-1], dp_x};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FOO_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issue_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (accept && stat_issue_cnt != '1)
        stat_issue_cnt <= stat_issue_cnt + 32'd1;
      if (|req_valid && !credit && stat_stall_cnt != '1)
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_foo_sched.sv
// Self-checking bench for foo_sched: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_foo_sched;
  localparam int NR = 2;
  localparam int IW = 1;
  localparam int L  = 2;
  localparam int D  = 4;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*64-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            dp_valid;
  logic [63:0]     dp_a;
  logic [128:0]    dp_long_in;
  logic [63:0]     dp_x;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [63:0]     rsp_data;
`ifdef FOO_SCHED_STATS_EN
  logic [31:0]     stat_issue_cnt;
  logic [31:0]     stat_stall_cnt;
`endif

  foo_sched #(.NUM_REQ(NR), .ID_W(IW), .DP_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .dp_valid(dp_valid), .dp_a(dp_a), .dp_long_in(dp_long_in),
    .dp_x(dp_x), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data)
`ifdef FOO_SCHED_STATS_EN
    , .stat_issue_cnt(stat_issue_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_x(input logic [63:0] d);
    return d ^ {d[50:0], d[63:51]};
  endfunction

  // Stand-in foo datapath: result depends on both halves of long_in, L cycles late.
  logic        dpv_p [L];
  logic [63:0] dpx_p [L];
  always @(posedge clk) begin
    dpv_p[0] <= dp_valid;
    dpx_p[0] <= (dp_long_in[127:64] ^ {dp_long_in[50:0], dp_long_in[63:51]}) + 64'(dp_long_in[128]);
    for (int k = 1; k < L; k++) begin
      dpv_p[k] <= dpv_p[k-1];
      dpx_p[k] <= dpx_p[k-1];
    end
  end
  assign dp_x = dpv_p[L-1] ? dpx_p[L-1] : 64'hDEAD_BEEF_DEAD_BEEF;

  // Reference model: ordered queue of accepted operations with their arrival cycle.
  typedef struct {
    int          id;
    logic [63:0] x;
    int          avail;
  } op_t;
  op_t         q[$];
  int          m_ptr = 0;
  int          cyc = 0;
  logic        m_dpv = 1'b0;
  logic [63:0] m_a = '0;

  function automatic int exp_grant();
    if (q.size() >= D) return -1;
    for (int i = 0; i < NR; i++) begin
      int j = (m_ptr + i) % NR;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_ptr = 0;
      cyc   = 0;
      m_dpv = 1'b0;
      m_a   = '0;
    end else begin
      int            g;
      logic [NR-1:0] er;
      logic          ev;
      g  = exp_grant();
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      ev = (q.size() > 0) && (q[0].avail <= cyc);
      check("m_req_ready", req_ready, er);
      check("m_dp_valid", dp_valid, m_dpv);
      check("m_dp_a", dp_a, m_a);
      check("m_dp_long_in", dp_long_in, {1'b0, m_a, m_a});
      check("m_rsp_valid", rsp_valid, ev);
      if (ev) begin
        check("m_rsp_id", rsp_id, q[0].id);
        check("m_rsp_data", rsp_data, q[0].x);
      end
      cyc++;
      if (ev && rsp_ready) void'(q.pop_front());
      m_dpv = 1'b0;
      if (g >= 0) begin
        m_dpv = 1'b1;
        m_a   = req_data[64*g +: 64];
        q.push_back('{g, ref_x(m_a), cyc + L + 1});
        m_ptr = (g + 1) % NR;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle, confirm outputs clear at once, release after two edges.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", req_ready, '0);
    check("rst_dp_valid", dp_valid, 1'b0);
    check("rst_dp_long_in", dp_long_in, '0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, '0);
    check("rst_rsp_data", rsp_data, '0);
    next_cycle();
    next_cycle();
    rst_n     = 1'b1;
    req_valid = '0;
  endtask

  typedef struct {
    logic [NR-1:0] rv;
    logic          rr;
    logic [NR-1:0] exp_ready;
  } vec_t;
  vec_t tbl [8];

  initial begin
    logic [63:0] d;
    int          ids[$];
    logic [63:0] datas[$];
    int          n_acc;
    logic [63:0] pd [3];

    tbl[0] = '{2'b11, 1'b1, 2'b01};
    tbl[1] = '{2'b11, 1'b1, 2'b10};
    tbl[2] = '{2'b11, 1'b1, 2'b01};
    tbl[3] = '{2'b11, 1'b1, 2'b10};
    tbl[4] = '{2'b11, 1'b1, 2'b00};
    tbl[5] = '{2'b11, 1'b1, 2'b01};
    tbl[6] = '{2'b11, 1'b1, 2'b10};
    tbl[7] = '{2'b00, 1'b1, 2'b00};

    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_data  = '0;
    rsp_ready = 1'b1;
    #2;
    apply_reset();

    // Single operation latency and datapath operand shape.
    d = 64'h0123_4567_89AB_CDEF;
    req_data  = {64'h0, d};
    req_valid = 2'b01;
    @(negedge clk);
    check("single_ready", req_ready, 2'b01);
    next_cycle();
    req_valid = '0;
    check("single_dp_valid", dp_valid, 1'b1);
    check("single_long_in", dp_long_in, {1'b0, d, d});
    next_cycle();
    check("single_rsp_early1", rsp_valid, 1'b0);
    next_cycle();
    check("single_rsp_early2", rsp_valid, 1'b0);
    next_cycle();
    check("single_rsp_valid", rsp_valid, 1'b1);
    check("single_rsp_id", rsp_id, '0);
    check("single_rsp_data", rsp_data, ref_x(d));
    repeat (3) next_cycle();

    // Round-robin vector table.
    apply_reset();
    ids.delete();
    for (int r = 0; r < 8; r++) begin
      req_valid = tbl[r].rv;
      rsp_ready = tbl[r].rr;
      req_data  = {64'hB000 + 64'(r), 64'hA000 + 64'(r)};
      @(negedge clk);
      check("rr_ready", req_ready, tbl[r].exp_ready);
      if (rsp_valid && rsp_ready) ids.push_back(int'(rsp_id));
      next_cycle();
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) ids.push_back(int'(rsp_id));
      next_cycle();
    end
    check("rr_rsp_count", ids.size(), 6);
    for (int k = 0; k < ids.size() && k < 6; k++) check("rr_rsp_id", ids[k], k % 2);

    // Backpressure: credit exhausts after FIFO_DEPTH accepts.
    apply_reset();
    rsp_ready = 1'b0;
    req_valid = 2'b10;
    req_data  = {64'hFACE_0000_1234_5678, 64'h0};
    n_acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_ready[1]) n_acc++;
      next_cycle();
    end
    check("bp_accepts", n_acc, 4);
    check("bp_blocked", req_ready, 2'b00);
`ifdef FOO_SCHED_STATS_EN
    check("stat_issue", stat_issue_cnt, 32'd4);
    check("stat_stall", stat_stall_cnt, 32'd6);
`endif
    rsp_ready = 1'b1;
    next_cycle();
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_regrant", req_ready, 2'b10);
    next_cycle();
    @(negedge clk);
    check("bp_reblock", req_ready, 2'b00);
    next_cycle();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (8) next_cycle();

    // Simultaneous push and pop with two entries queued.
    apply_reset();
    rsp_ready = 1'b0;
    pd[0] = 64'h1111_2222_3333_4444;
    pd[1] = 64'h5555_6666_7777_8888;
    pd[2] = 64'h9999_AAAA_BBBB_CCCC;
    for (int k = 0; k < 3; k++) begin
      req_valid = 2'b01;
      req_data  = {64'h0, pd[k]};
      next_cycle();
    end
    req_valid = '0;
    next_cycle();
    next_cycle();
    check("pp_head_a", rsp_data, ref_x(pd[0]));
    rsp_ready = 1'b1;
    next_cycle();
    rsp_ready = 1'b0;
    check("pp_head_b", rsp_data, ref_x(pd[1]));
    rsp_ready = 1'b1;
    datas.delete();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid) datas.push_back(rsp_data);
      next_cycle();
    end
    check("pp_occupancy", datas.size(), 2);
    if (datas.size() == 2) begin
      check("pp_order_b", datas[0], ref_x(pd[1]));
      check("pp_order_c", datas[1], ref_x(pd[2]));
    end

    // Reset with three operations outstanding.
    apply_reset();
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    req_data  = {64'h7, 64'h3};
    repeat (3) next_cycle();
    req_valid = 2'b11;
    apply_reset();
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("stale_rsp", rsp_valid, 1'b0);
      next_cycle();
    end
    req_valid = 2'b11;
    @(negedge clk);
    check("post_reset_prio", req_ready, 2'b01);
    next_cycle();
    req_valid = '0;
    repeat (6) next_cycle();

    // Randomized traffic against the model.
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = NR'($urandom);
      req_data  = {$urandom, $urandom, $urandom, $urandom};
      rsp_ready = ($urandom_range(0, 3) != 0);
      next_cycle();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (20) next_cycle();
    check("drain_empty", rsp_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
